interrupt_controller: RTL

- Parametrised interrupt controller for the CPU core, generalising the fixed 8-bit irq_in/irq_masks/irq_status path.
- Synchronises NUM_IRQ external requests and latches them per channel, in edge or level mode.
- Applies a programmable mask and resolves priority with the lowest index winning.
- Presents a registered vector to the microcode sequencer through a request/ack/end-of-interrupt handshake.

---
 rtl/interrupt_controller.sv | 85 ++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronised, maskable, lowest-index-first interrupt controller with req/ack/eoi handshake
module interrupt_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int VEC_W       = $clog2(NUM_IRQ),
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_mode,
  input  logic               mask_wrt,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               int_enable,
  input  logic               int_ack,
  input  logic               int_eoi,
  input  logic               clear_all_ints,
  output logic               int_request,
  output logic [VEC_W-1:0]   int_vector,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic               in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] s, p, rise, pending, ack_clr, status_nxt;
  logic [VEC_W-1:0] sel, vec_nxt;
  logic take_ack;
  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~p;
  assign pending  = irq_status & irq_masks;
  assign take_ack = (state == REQ) && int_ack && !clear_all_ints;
  assign ack_clr  = take_ack ? (NUM_IRQ'(1) << int_vector) : '0;
  // level channels track s; edge channels are sticky, a new edge beats an ack clear, a flush beats everything
  assign status_nxt = (~edge_mode & s) |
                      (edge_mode & {NUM_IRQ{~clear_all_ints}} & (rise | (irq_status & ~ack_clr)));
  // synchroniser chain plus one-cycle history for edge detection
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      sync_q <= '0;
      p      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      p      <= s;
    end
  // lowest set index of pending wins
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pending[i]) sel = VEC_W'(i);
  end
  // next-state: flush overrides, otherwise IDLE -> REQ -> SERVICE -> IDLE
  always_comb begin
    state_nxt = state;
    vec_nxt   = int_vector;
    if (clear_all_ints) state_nxt = IDLE;
    else
      case (state)
        IDLE: if (|pending && int_enable) begin
          state_nxt = REQ;
          vec_nxt   = sel;
        end
        REQ:     if (int_ack) state_nxt = SERVICE;
        SERVICE: if (int_eoi) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
  end
  // state, vector, status, mask and handshake outputs, all registered
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state       <= IDLE;
      int_vector  <= '0;
      irq_status  <= '0;
      irq_masks   <= '0;
      int_request <= 1'b0;
      in_service  <= 1'b0;
    end else begin
      state       <= state_nxt;
      int_vector  <= vec_nxt;
      irq_status  <= status_nxt;
      irq_masks   <= mask_wrt ? mask_data : irq_masks;
      int_request <= (state_nxt == REQ) && int_enable;
      in_service  <= state_nxt == SERVICE;
    end
endmodule
